// File: rtl/rf_pkg.sv
//------------------------------------------------------------------------------
// Module  : rf_pkg
// Brief   : Shared widths, state type and decode helper for the RF write-back.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 2**RF_ADDR_W;
  localparam int STARVE_W    = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } wb_state_t;

  function automatic logic [RF_NUM_REGS-1:0] onehot(input logic [RF_ADDR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_prio_arb.sv
//------------------------------------------------------------------------------
// Module  : wb_prio_arb
// Brief   : Two-way A-first arbiter; B is promoted after STARVE_MAX denials.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_prio_arb
  import rf_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  localparam logic [STARVE_W-1:0] c_max = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_starve;
  logic                w_b_first;
  logic                w_open;

  assign w_open    = en && !hold;
  assign w_b_first = b_valid && (r_starve == c_max);
  assign a_grant   = w_open && a_valid && !w_b_first;
  assign b_grant   = w_open && b_valid && (w_b_first || !a_valid);

  // Denials only accumulate while the port is running; a clr cycle counts as a denial.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!b_valid || b_grant) begin
      r_starve <= '0;
    end else if (en && (r_starve != c_max)) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rf_wb_arbiter
// Brief   : Owns the register-file write port: zero-fill sweeps plus A/B write-back.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_reg,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_reg,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 clr_req,
  output logic                 rf_wen,
  output logic [ADDR_W-1:0]    rf_dst,
  output logic [DATA_W-1:0]    rf_data,
  output logic                 init_done,
  output logic [2**ADDR_W-1:0] busy_mask
);

  localparam int c_num_regs = 2**ADDR_W;

  wb_state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_sweep_cnt, w_sweep_nxt;
  logic                  r_wen, w_wen_nxt;
  logic [ADDR_W-1:0]     r_dst, w_dst_nxt;
  logic [DATA_W-1:0]     r_data, w_data_nxt;
  logic                  w_run;
  logic                  w_a_grant, w_b_grant;
  logic [c_num_regs-1:0] w_busy;

  assign w_run = (r_state == ST_RUN);

  wb_prio_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (w_run && !rst),
    .hold    (clr_req),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_grant (w_a_grant),
    .b_grant (w_b_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_cnt;
    w_wen_nxt   = 1'b0;
    w_dst_nxt   = r_dst;
    w_data_nxt  = r_data;
    case (r_state)
      ST_INIT, ST_CLEAR: begin
        w_wen_nxt   = 1'b1;
        w_dst_nxt   = r_sweep_cnt;
        w_data_nxt  = '0;
        w_sweep_nxt = r_sweep_cnt + ADDR_W'(1);
        if (&r_sweep_cnt) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
        end else if (w_a_grant) begin
          w_wen_nxt  = 1'b1;
          w_dst_nxt  = a_reg;
          w_data_nxt = a_data;
        end else if (w_b_grant) begin
          w_wen_nxt  = 1'b1;
          w_dst_nxt  = b_reg;
          w_data_nxt = b_data;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_sweep_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_sweep_cnt <= '0;
      r_wen       <= 1'b0;
      r_dst       <= '0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_nxt;
      r_wen       <= w_wen_nxt;
      r_dst       <= w_dst_nxt;
      r_data      <= w_data_nxt;
    end
  end

  // A register is busy while a requester targets it or the port is driving it.
  for (genvar r = 0; r < c_num_regs; r++) begin : g_busy
    assign w_busy[r] = (a_valid && (a_reg == ADDR_W'(r))) ||
                       (b_valid && (b_reg == ADDR_W'(r))) ||
                       (r_wen   && (r_dst == ADDR_W'(r)));
  end

  assign busy_mask = w_run ? w_busy : '1;
  assign a_ready   = w_a_grant;
  assign b_ready   = w_b_grant;
  assign init_done = w_run;
  assign rf_wen    = r_wen;
  assign rf_dst    = r_dst;
  assign rf_data   = r_data;

endmodule

`default_nettype wire
